// File: rtl/console_pkg.sv
// Register offsets, STATUS layout, UART states and halt exit codes for the console.
// Shared by mmio_console_tx; holds no logic besides the exit-code encoder.
package console_pkg;

    localparam logic [31:0] TXDATA_OFS = 32'h0;
    localparam logic [31:0] STATUS_OFS = 32'h4;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic [1:0] EXIT_RUN    = 2'd0;
    localparam logic [1:0] EXIT_ECALL  = 2'd1;
    localparam logic [1:0] EXIT_EBREAK = 2'd2;
    localparam logic [1:0] EXIT_BOTH   = 2'd3;

    function automatic logic [1:0] halt_code(input logic ecall, input logic ebreak);
        if (ecall && ebreak) return EXIT_BOTH;
        if (ebreak)          return EXIT_EBREAK;
        if (ecall)           return EXIT_ECALL;
        return EXIT_RUN;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; push/pop take effect on the clock edge.
// Push while full is accepted only together with a pop; push_ok reports acceptance.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       push_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_console_tx.sv
// MMIO console: TXDATA stores queue bytes for an 8N1 UART; Ecall/Ebreak halt once drained.
// Push to start bit is one cycle; a full FIFO drops the byte and sets sticky overflow.
module mmio_console_tx
    import console_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        Ecall,
    input  logic        Ebreak,
    output logic [31:0] ReadData,
    output logic        sel,
    output logic        tx,
    output logic        done,
    output logic [1:0]  exit_code
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);

    uart_state_e   state;
    logic [BW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          overflow;
    logic          halt_pend;

    logic          hit_tx, hit_st, wr_tx, wr_st;
    logic          full, empty, push_ok, pop, last_tick;
    logic [7:0]    pop_dat;
    logic [CW-1:0] count;
    logic [31:0]   status;
    logic          unused_wdata;

    assign hit_tx = (DataAdr == BASE_ADDR + TXDATA_OFS);
    assign hit_st = (DataAdr == BASE_ADDR + STATUS_OFS);
    assign sel    = hit_tx || hit_st;
    assign wr_tx  = MemWrite && hit_tx && !halt_pend;
    assign wr_st  = MemWrite && hit_st && !halt_pend;
    assign unused_wdata = ^WriteData[31:8];

    always_comb begin
        status                     = '0;
        status[ST_FULL]            = full;
        status[ST_EMPTY]           = empty;
        status[ST_BUSY]            = (state != IDLE);
        status[ST_OVF]             = overflow;
        status[ST_CNT_LSB +: 8]    = 8'(count);
    end

    assign ReadData = hit_st ? status : '0;

    // A new frame may begin from IDLE or straight out of the stop bit, so frames abut.
    assign last_tick = (clk_cnt == BW'(CLKS_PER_BIT - 1));
    assign pop       = !empty && ((state == IDLE) || (state == STOP && last_tick));

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (wr_tx),
        .push_dat (WriteData[7:0]),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .push_ok  (push_ok)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shreg   <= '0;
            clk_cnt <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= pop_dat;
                        state   <= START;
                        tx      <= 1'b0;
                        clk_cnt <= '0;
                    end
                end
                START: begin
                    if (last_tick) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end else begin
                        clk_cnt <= clk_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (last_tick) begin
                        clk_cnt <= '0;
                        if (pop) begin
                            shreg <= pop_dat;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only the first halt event is recorded; done waits for the UART to go fully quiet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            halt_pend <= 1'b0;
            exit_code <= EXIT_RUN;
            done      <= 1'b0;
        end else begin
            if (wr_st && WriteData[ST_OVF])
                overflow <= 1'b0;
            else if (wr_tx && !push_ok)
                overflow <= 1'b1;
            if (!halt_pend && (Ecall || Ebreak)) begin
                halt_pend <= 1'b1;
                exit_code <= halt_code(Ecall, Ebreak);
            end
            done <= done || (halt_pend && empty && state == IDLE);
        end
    end

endmodule

// File: tb/tb_mmio_console_tx.sv
// Bench for mmio_console_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; a UART receiver
// checks every frame against a queue of bytes the stimulus expects to be sent.
module tb_mmio_console_tx;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        Ecall = 1'b0;
    logic        Ebreak = 1'b0;
    logic [31:0] ReadData;
    logic        sel, tx, done;
    logic [1:0]  exit_code;

    int n_cmp = 0;
    int n_bad = 0;
    int reset_gen = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] adr;
        logic [31:0] rd;
        logic        sl;
    } vec_t;
    vec_t vt[6];

    mmio_console_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .Ecall     (Ecall),
        .Ebreak    (Ebreak),
        .ReadData  (ReadData),
        .sel       (sel),
        .tx        (tx),
        .done      (done),
        .exit_code (exit_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        MemWrite  = 1'b0;
        Ecall     = 1'b0;
        Ebreak    = 1'b0;
        DataAdr   = BASE + 32'h4;
        WriteData = '0;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] dat);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = dat;
        @(posedge clk);
        #1 idle_bus();
    endtask

    task automatic halt_pulse(input logic ec, input logic eb);
        Ecall  = ec;
        Ebreak = eb;
        @(posedge clk);
        #1 idle_bus();
    endtask

    task automatic do_reset();
        reset_gen++;
        exp_q.delete();
        idle_bus();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic read_status(output logic [31:0] v);
        DataAdr = BASE + 32'h4;
        #1 v = ReadData;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int k;
        k = 0;
        while (!(ReadData[1] && !ReadData[2]) && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(k < bound), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // UART receiver: samples mid-bit, drops frames cut short by a reset.
    initial begin
        int g;
        logic [9:0] fr;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && tx === 1'b0) begin
                g = reset_gen;
                repeat (CPB / 2) @(negedge clk);
                fr[0] = tx;
                for (int b = 1; b < 10; b++) begin
                    repeat (CPB) @(negedge clk);
                    fr[b] = tx;
                end
                if (g == reset_gen) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rx_unexpected: got frame 0x%0h, want no frame", fr);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_frame", 64'(fr), 64'({1'b1, e, 1'b0}));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] cap, expv;
        logic [7:0]  d;
        logic [31:0] v;
        logic        b0, b1;
        int          first_done;

        idle_bus();
        vt[0] = '{BASE,                 32'h0, 1'b1};
        vt[1] = '{BASE + 32'h4,         32'h2, 1'b1};
        vt[2] = '{BASE + 32'h8,         32'h0, 1'b0};
        vt[3] = '{BASE - 32'h4,         32'h0, 1'b0};
        vt[4] = '{BASE + 32'h5,         32'h0, 1'b0};
        vt[5] = '{32'h2000_0004,        32'h0, 1'b0};

        #12;
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_exit", 64'(exit_code), 64'd0);
        for (int i = 0; i < 6; i++) begin
            DataAdr = vt[i].adr;
            #1;
            check($sformatf("vec%0d_sel", i), 64'(sel), 64'(vt[i].sl));
            check($sformatf("vec%0d_rdata", i), 64'(ReadData), 64'(vt[i].rd));
        end
        idle_bus();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame 0x41: exact waveform and frame length.
        d = 8'h41;
        for (int i = 0; i < 40; i++)
            expv[i] = (i < 4) ? 1'b0 : (i < 36) ? d[(i - 4) / 4] : 1'b1;
        exp_q.push_back(d);
        store(BASE, 32'h41);
        @(negedge clk);
        check("tx_before_start", 64'(tx), 64'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cap[i] = tx;
            b0 = ReadData[2];
        end
        check("frame_0x41", 64'(cap), 64'(expv));
        check("busy_last_cycle", 64'(b0), 64'd1);
        @(negedge clk);
        check("busy_after_frame", 64'(ReadData[2]), 64'd0);
        @(posedge clk);
        #1;

        // Six back-to-back stores into a four-entry FIFO.
        for (int i = 0; i < 6; i++) begin
            MemWrite  = 1'b1;
            DataAdr   = BASE;
            WriteData = 32'h30 + 32'(i);
            if (i < 5) exp_q.push_back(8'h30 + 8'(i));
            @(posedge clk);
            #1;
        end
        idle_bus();
        read_status(v);
        check("status_overflow", 64'(v), 64'h0000_040D);
        store(BASE + 32'h4, 32'h8);
        read_status(v);
        check("status_ovf_cleared", 64'(v), 64'h0000_0405);
        wait_idle(400, "drain_overflow");
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // Store then Ecall next cycle: done only after the stop bit.
        exp_q.push_back(8'h55);
        store(BASE, 32'h55);
        halt_pulse(1'b1, 1'b0);
        check("exit_ecall", 64'(exit_code), 64'd1);
        first_done = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done && first_done == 0) first_done = k;
        end
        check("done_latency_ecall", 64'(first_done), 64'd42);
        @(posedge clk);
        #1;
        halt_pulse(1'b0, 1'b1);
        check("exit_first_only", 64'(exit_code), 64'd1);
        check("done_sticky", 64'(done), 64'd1);

        // Ecall and Ebreak together with an empty FIFO.
        do_reset();
        halt_pulse(1'b1, 1'b1);
        @(negedge clk);
        b0 = done;
        @(negedge clk);
        b1 = done;
        check("done_next_cycle", 64'({b0, b1}), 64'b01);
        check("exit_both", 64'(exit_code), 64'd3);
        @(posedge clk);
        #1;
        store(BASE, 32'h77);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cap[i] = tx;
        end
        check("tx_quiet_after_halt", 64'(cap[19:0]), 64'hF_FFFF);
        @(posedge clk);
        #1;
        read_status(v);
        check("status_after_halt", 64'(v), 64'h2);

        // Reset in the middle of DATA bit 3 of 0xA5.
        do_reset();
        exp_q.push_back(8'hA5);
        store(BASE, 32'hA5);
        repeat (17) @(posedge clk);
        #3;
        check("tx_bit3_before_reset", 64'(tx), 64'd0);
        reset_gen++;
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        check("tx_async_reset", 64'(tx), 64'd1);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        read_status(v);
        check("status_after_abort", 64'(v), 64'h2);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cap[i] = tx;
        end
        check("no_resumed_frame", 64'(cap), 64'hFF_FFFF_FFFF);
        check("queue_final", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
